// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the CPU-to-cache word bridge.
//   SZ_*          : cpu_size encodings (3 is illegal)
//   state_t       : bridge sequencer states
//   is_misaligned : flags illegal sizes and unaligned half/word addresses
package mem_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_LO,
    ST_GAP,
    ST_ISSUE_HI,
    ST_DONE
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load result formatter (purely combinational).
//   hi, lo    : upper / lower 16-bit halves returned by the cache
//   byte_sel  : byte address bit 0, picks lane [15:8] when set
//   size      : access size encoding
//   is_signed : sign-extend byte/half results
//   data      : right-aligned, extended 32-bit load result
module mem_load_align (
  input  logic [15:0] hi,
  input  logic [15:0] lo,
  input  logic        byte_sel,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);
  import mem_bridge_pkg::*;

  logic [7:0] lane;

  always_comb begin
    lane = byte_sel ? lo[15:8] : lo[7:0];
    case (size)
      SZ_BYTE: data = {{24{is_signed & lane[7]}}, lane};
      SZ_HALF: data = {{16{is_signed & lo[15]}}, lo};
      default: data = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mem_word_bridge.sv
// Converts 32-bit CPU byte/half/word accesses into one or two 16-bit cache
// transactions over the rw_req/data_valid handshake.
//   clk, reset          : clock, synchronous active-high reset
//   cpu_*               : CPU request in, single-cycle cpu_ready/cpu_err out
//   mc_*                : registered request to the cache, held stable for the
//                         whole handshake; mc_read_data/mc_data_valid back
// A watchdog aborts a half-transaction that sees no data_valid for TIMEOUT
// consecutive issue cycles.
module mem_word_bridge #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic        mc_ce,
  output logic [31:0] mc_address,
  output logic [1:0]  mc_be,
  output logic        mc_rw_req,
  output logic        mc_rw,
  output logic [15:0] mc_write_data,
  input  logic [15:0] mc_read_data,
  input  logic        mc_data_valid
);
  import mem_bridge_pkg::*;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic               signed_q, signed_d;
  logic               byte_sel_q, byte_sel_d;
  logic [1:0]         size_q, size_d;
  logic [15:0]        wdata_hi_q, wdata_hi_d;
  logic [15:0]        lo_q, lo_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d, wdog_inc;

  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic               cpu_ready_q, cpu_ready_d;
  logic               cpu_err_q, cpu_err_d;
  logic               mc_ce_q, mc_ce_d;
  logic [31:0]        mc_address_q, mc_address_d;
  logic [1:0]         mc_be_q, mc_be_d;
  logic               mc_rw_req_q, mc_rw_req_d;
  logic               mc_rw_q, mc_rw_d;
  logic [15:0]        mc_write_data_q, mc_write_data_d;

  logic [15:0]        align_lo;
  logic [31:0]        align_data;

  // The completing half is formatted straight from mc_read_data so the
  // result is registered on the same edge that ends the handshake.
  assign align_lo = (state_q == ST_ISSUE_HI) ? lo_q : mc_read_data;

  mem_load_align u_align (
    .hi        (mc_read_data),
    .lo        (align_lo),
    .byte_sel  (byte_sel_q),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (align_data)
  );

  assign wdog_inc = wdog_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    signed_d        = signed_q;
    byte_sel_d      = byte_sel_q;
    size_d          = size_q;
    wdata_hi_d      = wdata_hi_q;
    lo_d            = lo_q;
    wdog_d          = wdog_q;
    cpu_rdata_d     = 32'd0;
    cpu_ready_d     = 1'b0;
    cpu_err_d       = 1'b0;
    mc_ce_d         = mc_ce_q;
    mc_address_d    = mc_address_q;
    mc_be_d         = mc_be_q;
    mc_rw_req_d     = mc_rw_req_q;
    mc_rw_d         = mc_rw_q;
    mc_write_data_d = mc_write_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          we_d       = cpu_we;
          signed_d   = cpu_signed;
          byte_sel_d = cpu_addr[0];
          size_d     = cpu_size;
          wdata_hi_d = cpu_wdata[31:16];
          if (is_misaligned(cpu_size, cpu_addr[1:0])) begin
            state_d     = ST_DONE;
            cpu_ready_d = 1'b1;
            cpu_err_d   = 1'b1;
          end else begin
            state_d     = ST_ISSUE_LO;
            wdog_d      = '0;
            mc_rw_req_d = 1'b1;
            mc_ce_d     = 1'b1;
            mc_rw_d     = cpu_we;
            if (cpu_size == SZ_WORD) begin
              mc_address_d = {cpu_addr[31:2], 2'b00};
            end else begin
              mc_address_d = {cpu_addr[31:1], 1'b0};
            end
            if (cpu_size == SZ_BYTE) begin
              mc_be_d         = cpu_addr[0] ? 2'b10 : 2'b01;
              mc_write_data_d = {cpu_wdata[7:0], cpu_wdata[7:0]};
            end else begin
              mc_be_d         = 2'b11;
              mc_write_data_d = cpu_wdata[15:0];
            end
          end
        end
      end

      ST_ISSUE_LO, ST_ISSUE_HI: begin
        if (mc_data_valid) begin
          mc_rw_req_d = 1'b0;
          mc_ce_d     = 1'b0;
          if (state_q == ST_ISSUE_LO) begin
            lo_d = mc_read_data;
          end
          if ((state_q == ST_ISSUE_LO) && (size_q == SZ_WORD)) begin
            state_d = ST_GAP;
          end else begin
            state_d     = ST_DONE;
            cpu_ready_d = 1'b1;
            cpu_rdata_d = we_q ? 32'd0 : align_data;
          end
        end else if (wdog_inc == CNT_W'(TIMEOUT)) begin
          mc_rw_req_d = 1'b0;
          mc_ce_d     = 1'b0;
          state_d     = ST_DONE;
          cpu_ready_d = 1'b1;
          cpu_err_d   = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      // One idle cycle lets the cache see rw_req low before the second half.
      ST_GAP: begin
        state_d         = ST_ISSUE_HI;
        wdog_d          = '0;
        mc_rw_req_d     = 1'b1;
        mc_ce_d         = 1'b1;
        mc_address_d    = mc_address_q | 32'h0000_0002;
        mc_be_d         = 2'b11;
        mc_write_data_d = wdata_hi_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      we_q            <= 1'b0;
      signed_q        <= 1'b0;
      byte_sel_q      <= 1'b0;
      size_q          <= SZ_BYTE;
      wdata_hi_q      <= 16'd0;
      lo_q            <= 16'd0;
      wdog_q          <= '0;
      cpu_rdata_q     <= 32'd0;
      cpu_ready_q     <= 1'b0;
      cpu_err_q       <= 1'b0;
      mc_ce_q         <= 1'b0;
      mc_address_q    <= 32'd0;
      mc_be_q         <= 2'b00;
      mc_rw_req_q     <= 1'b0;
      mc_rw_q         <= 1'b0;
      mc_write_data_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      signed_q        <= signed_d;
      byte_sel_q      <= byte_sel_d;
      size_q          <= size_d;
      wdata_hi_q      <= wdata_hi_d;
      lo_q            <= lo_d;
      wdog_q          <= wdog_d;
      cpu_rdata_q     <= cpu_rdata_d;
      cpu_ready_q     <= cpu_ready_d;
      cpu_err_q       <= cpu_err_d;
      mc_ce_q         <= mc_ce_d;
      mc_address_q    <= mc_address_d;
      mc_be_q         <= mc_be_d;
      mc_rw_req_q     <= mc_rw_req_d;
      mc_rw_q         <= mc_rw_d;
      mc_write_data_q <= mc_write_data_d;
    end
  end

  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_ready     = cpu_ready_q;
  assign cpu_err       = cpu_err_q;
  assign mc_ce         = mc_ce_q;
  assign mc_address    = mc_address_q;
  assign mc_be         = mc_be_q;
  assign mc_rw_req     = mc_rw_req_q;
  assign mc_rw         = mc_rw_q;
  assign mc_write_data = mc_write_data_q;

endmodule

// File: tb/tb_mem_word_bridge.sv
// Scoreboard bench for mem_word_bridge: expected cache transactions and CPU
// completions are queued as each request is driven; a cache model and a CPU
// monitor pop and compare them as the DUT produces them.
module tb_mem_word_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'd0;
  logic        cpu_signed = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic        mc_ce;
  logic [31:0] mc_address;
  logic [1:0]  mc_be;
  logic        mc_rw_req;
  logic        mc_rw;
  logic [15:0] mc_write_data;
  logic [15:0] mc_read_data = 16'd0;
  logic        mc_data_valid = 1'b0;

  always #5 clk = ~clk;

  mem_word_bridge #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_size      (cpu_size),
    .cpu_signed    (cpu_signed),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ready     (cpu_ready),
    .cpu_err       (cpu_err),
    .mc_ce         (mc_ce),
    .mc_address    (mc_address),
    .mc_be         (mc_be),
    .mc_rw_req     (mc_rw_req),
    .mc_rw         (mc_rw),
    .mc_write_data (mc_write_data),
    .mc_read_data  (mc_read_data),
    .mc_data_valid (mc_data_valid)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  be;
    logic        rw;
    logic [15:0] wd;
    logic [15:0] rd;
    int          lat;   // cycles after rw_req rise to data_valid; -1 = never
  } mc_txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;   // cycle count at which cpu_ready must be seen
  } cpu_exp_t;

  mc_txn_t  mc_q[$];
  cpu_exp_t cpu_q[$];

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  bit model_en = 1'b1;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_mc(input logic [31:0] addr, input logic [1:0] be, input logic rw,
                         input logic [15:0] wd, input logic [15:0] rd, input int lat);
    mc_txn_t t;
    t.addr = addr; t.be = be; t.rw = rw; t.wd = wd; t.rd = rd; t.lat = lat;
    mc_q.push_back(t);
  endtask

  // Cache model: pops an expected transaction on each rw_req rise.
  initial begin
    mc_txn_t cur;
    bit busy;
    int cyc;
    busy = 1'b0;
    cyc = 0;
    cur.addr = 0; cur.be = 0; cur.rw = 0; cur.wd = 0; cur.rd = 0; cur.lat = -1;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 1'b0;
        if (model_en) mc_data_valid = 1'b0;
      end else if (model_en) begin
        if (mc_data_valid) begin
          mc_data_valid = 1'b0;
          busy = 1'b0;
          chk("rw_req_drop", mc_rw_req, 1'b0);
        end else if (busy) begin
          cyc++;
          if (!mc_rw_req) begin
            chk("abort_len", cyc, (cur.lat < 0) ? TO : -1);
            busy = 1'b0;
          end else begin
            chk("hold_addr", mc_address, cur.addr);
            chk("hold_be", mc_be, cur.be);
            chk("hold_ce", mc_ce, 1'b1);
            if (cyc == cur.lat) begin
              mc_data_valid = 1'b1;
              mc_read_data = cur.rd;
            end
          end
        end else if (mc_rw_req) begin
          if (mc_q.size() == 0) begin
            chk("unexpected_mc_req", mc_address, 32'hFFFF_FFFF);
          end else begin
            cur = mc_q.pop_front();
            $display("mc  addr=%h be=%b rw=%b wd=%h", mc_address, mc_be, mc_rw, mc_write_data);
            chk("mc_addr", mc_address, cur.addr);
            chk("mc_be", mc_be, cur.be);
            chk("mc_rw", mc_rw, cur.rw);
            chk("mc_ce", mc_ce, 1'b1);
            if (cur.rw) chk("mc_wdata", mc_write_data, cur.wd);
            busy = 1'b1;
            cyc = 0;
          end
        end
      end
    end
  end

  // CPU monitor: every cpu_ready pulse pops one expected completion.
  initial begin
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && cpu_ready) begin
        if (cpu_q.size() == 0) begin
          chk("unexpected_ready", cpu_ready, 1'b0);
        end else begin
          e = cpu_q.pop_front();
          $display("cpu rdata=%h err=%b cyc=%0d", cpu_rdata, cpu_err, cyc_cnt);
          chk("cpu_rdata", cpu_rdata, e.rdata);
          chk("cpu_err", cpu_err, e.err);
          chk("ready_cycle", cyc_cnt, e.due);
        end
      end else if (!reset && cpu_err) begin
        chk("err_without_ready", cpu_err, 1'b0);
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input bit poke);
    cpu_exp_t e;
    @(negedge clk);
    e.rdata = exp_rd; e.err = exp_err; e.due = cyc_cnt + 1 + lat;
    cpu_q.push_back(e);
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_signed = sgn;
    cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    if (poke) begin
      // A request while busy must be dropped, not queued.
      cpu_addr = 32'h0000_9000;
      @(negedge clk);
    end
    cpu_req = 1'b0;
    for (int i = 0; i < 200 && cpu_q.size() != 0; i++) @(negedge clk);
    if (cpu_q.size() != 0) begin
      chk("ready_timeout", cpu_q.size(), 0);
      cpu_q.delete();
    end
    chk("mc_left", mc_q.size(), 0);
    mc_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", cpu_ready, 1'b0);
    chk("rst_err", cpu_err, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_rw_req", mc_rw_req, 1'b0);
    chk("rst_ce", mc_ce, 1'b0);
    chk("rst_rw", mc_rw, 1'b0);
    chk("rst_be", mc_be, 2'b00);
    chk("rst_addr", mc_address, 32'd0);
    chk("rst_wdata", mc_write_data, 16'd0);
    reset = 1'b0;

    // Word load with a poke while busy.
    push_mc(32'h0000_1004, 2'b11, 1'b0, 16'h0, 16'hBEEF, 2);
    push_mc(32'h0000_1006, 2'b11, 1'b0, 16'h0, 16'hDEAD, 3);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2 + 3 + 3, 1'b1);

    // Byte and half loads, signed and unsigned.
    push_mc(32'h0000_2000, 2'b10, 1'b0, 16'h0, 16'h80FF, 1);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_2001, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1'b0);
    push_mc(32'h0000_2000, 2'b10, 1'b0, 16'h0, 16'h80FF, 4);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'h0, 32'h0000_0080, 1'b0, 5, 1'b0);
    push_mc(32'h0000_2000, 2'b01, 1'b0, 16'h0, 16'h80FF, 1);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_2000, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 1'b0);
    push_mc(32'h0000_2002, 2'b11, 1'b0, 16'h0, 16'h8001, 2);
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'hFFFF_8001, 1'b0, 3, 1'b0);
    push_mc(32'h0000_2006, 2'b11, 1'b0, 16'h0, 16'h8001, 2);
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_2006, 32'h0, 32'h0000_8001, 1'b0, 3, 1'b0);

    // Stores.
    push_mc(32'h0000_3002, 2'b10, 1'b1, 16'hA5A5, 16'h1234, 1);
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_3003, 32'h0000_00A5, 32'h0, 1'b0, 2, 1'b0);
    push_mc(32'h0000_3004, 2'b01, 1'b1, 16'h5A5A, 16'h0, 1);
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_3004, 32'hFFFF_FF5A, 32'h0, 1'b0, 2, 1'b0);
    push_mc(32'h0000_5000, 2'b11, 1'b1, 16'h5678, 16'hFFFF, 1);
    push_mc(32'h0000_5002, 2'b11, 1'b1, 16'h1234, 16'hFFFF, 1);
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_5000, 32'h1234_5678, 32'h0, 1'b0, 1 + 1 + 3, 1'b0);

    // Misaligned and illegal size: error in the cycle after the request.
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_4002, 32'h1, 32'h0, 1'b1, 0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_4001, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 1'b1, 0, 1'b0);

    // Watchdog abort, then a normal access.
    push_mc(32'h0000_6000, 2'b01, 1'b0, 16'h0, 16'h0, -1);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_6000, 32'h0, 32'h0, 1'b1, TO, 1'b0);
    push_mc(32'h0000_6002, 2'b11, 1'b0, 16'h0, 16'h1234, 1);
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_6002, 32'h0, 32'h0000_1234, 1'b0, 2, 1'b0);

    // Reset during the second half of a word load.
    push_mc(32'h0000_7000, 2'b11, 1'b0, 16'h0, 16'h1111, 2);
    push_mc(32'h0000_7002, 2'b11, 1'b0, 16'h0, 16'h0, -1);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h0000_7000;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 50 && !(mc_rw_req && mc_address == 32'h0000_7002); i++) @(negedge clk);
    chk("hi_issued", mc_address, 32'h0000_7002);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rw_req", mc_rw_req, 1'b0);
    chk("rst_mid_ready", cpu_ready, 1'b0);
    reset = 1'b0;
    chk("rst_mid_mc_left", mc_q.size(), 0);
    mc_q.delete();
    model_en = 1'b0;
    @(negedge clk);
    mc_read_data = 16'hFFFF;
    mc_data_valid = 1'b1;
    @(negedge clk);
    mc_data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_ready", cpu_ready, 1'b0);
      chk("stray_rw_req", mc_rw_req, 1'b0);
      @(negedge clk);
    end
    model_en = 1'b1;
    push_mc(32'h0000_8000, 2'b11, 1'b0, 16'h0, 16'h3344, 1);
    push_mc(32'h0000_8002, 2'b11, 1'b0, 16'h0, 16'h1122, 2);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0, 32'h1122_3344, 1'b0, 1 + 2 + 3, 1'b0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc_cnt);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/mem_word_bridge.md
Name: mem_word_bridge

Overview:
Upstream neighbour of the 16-bit SDRAM cache controller; converts 32-bit CPU load/store requests (byte/half/word) into one or two 16-bit cache transactions using the cache's rw_req/data_valid handshake. Handles byte-lane steering, store byte enables, load sign/zero extension and misalignment rejection. A watchdog aborts a transaction whose data_valid never arrives. Output is a single-cycle cpu_ready completion pulse with read data.

Parameters:
TIMEOUT, 1023, max cycles waiting for mc_data_valid per half-transaction before abort (>=1)
CNT_W, $clog2(TIMEOUT+1), watchdog counter width (derived)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  request; sampled only in IDLE
cpu_we  in  1  1=store, 0=load
cpu_size  in  2  0=byte, 1=half, 2=word, 3=illegal
cpu_signed  in  1  sign-extend byte/half loads
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data, right-aligned
cpu_rdata  out  32  load result, valid with cpu_ready
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  one-cycle, coincident with cpu_ready on error
mc_ce  out  1  cache enable, high while a half-transaction is issued
mc_address  out  32  halfword address to cache, bit0 = 0
mc_be  out  2  byte enables (bit1 = [15:8])
mc_rw_req  out  1  cache request level
mc_rw  out  1  1=write
mc_write_data  out  16  write data
mc_read_data  in  16  cache read data, valid in the mc_data_valid cycle
mc_data_valid  in  1  one-cycle cache completion

Behaviour:
- Reset: state IDLE; cpu_ready, cpu_err, mc_rw_req, mc_ce, mc_rw = 0; mc_be = 0; cpu_rdata, mc_address, mc_write_data = 0; watchdog = 0. Reset mid-transaction drops mc_rw_req the next cycle with no cpu_ready.
- All mc_* outputs are registered and held stable from rw_req rise through the data_valid cycle; the cache does not latch them.
- States: IDLE, ISSUE_LO, GAP, ISSUE_HI, DONE.
- IDLE: on cpu_req, latch all cpu_* inputs. Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size==3 -> DONE with err, no cache access. Otherwise -> ISSUE_LO.
- ISSUE_LO: mc_rw_req=mc_ce=1; mc_address={addr[31:1],0} for byte/half, {addr[31:2],00} for word.
- Byte: be=addr[0]?10:01, write_data={wdata[7:0],wdata[7:0]}. Half: be=11, write_data=wdata[15:0]. Word lo: be=11, wdata[15:0].
- On mc_data_valid: capture mc_read_data; word -> GAP, else -> DONE. Requests drop on the same edge.
- GAP: rw_req=0 for exactly one cycle so the cache returns to idle without re-triggering.
- ISSUE_HI: address {addr[31:2],10}, be=11, wdata[31:16]; on data_valid capture -> DONE.
- DONE: cpu_ready=1 one cycle. Load result: byte lane addr[0] selects [15:8]/[7:0]; byte/half extended per cpu_signed; word = {hi,lo}. Stores return rdata=0. -> IDLE. A new cpu_req is accepted the cycle after DONE.
- Watchdog: reset on entering ISSUE_*, increments each ISSUE cycle without data_valid. At count==TIMEOUT: drop rw_req, go to DONE with cpu_err=1 and rdata=0.
- data_valid outside ISSUE_* is ignored.
- cpu_req while busy is ignored (not queued).
- Latency: a single-half access with cache response k cycles after rw_req rise gives cpu_ready k+1 cycles after rise. A word access adds GAP plus the second response.

Decomposition:
- Package mem_bridge_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, misalignment check function.
- Sub-module mem_load_align (combinational): lane select plus sign/zero extension from {hi,lo}, addr[0], size, signed.

Test Plan:
- Word load addr 0x0000_1004, cache returns 0xBEEF then 0xDEAD -> two transactions at 0x1004 and 0x1006, one GAP cycle with rw_req=0, cpu_rdata=0xDEADBEEF, single cpu_ready.
- Signed byte load addr 0x0000_2001, read_data 0x80FF -> mc_address 0x2000, cpu_rdata 0xFFFFFF80. Unsigned -> 0x00000080.
- Byte store addr 0x3003, wdata 0x000000A5 -> one transaction at 0x3002, be=10, write_data 0xA5A5, rw=1.
- Word store addr 0x4002 -> no mc_rw_req ever, cpu_ready=cpu_err=1 the cycle after request. Half at 0x4001 behaves the same.
- Cache never asserts data_valid with TIMEOUT=8 -> rw_req drops after 8 ISSUE cycles, cpu_err pulse. A following request completes normally.
- Reset asserted during ISSUE_HI -> next cycle rw_req=0, state IDLE, no cpu_ready. Stray data_valid afterwards is ignored.
